// File: rtl/sensor_debounce.sv
// Two-channel vehicle-sensor conditioner: synchroniser + debounce FSM per road,
// rising-edge pulses, and a free-running timebase tick for the light controller.
module sensor_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 1000,
    parameter int unsigned TICK_DIV    = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic sa_raw,
    input  logic sb_raw,
    output logic sa,
    output logic sb,
    output logic sa_rise,
    output logic sb_rise,
    output logic tick
);

    localparam int unsigned CNT_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TICK_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_LO     = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HI     = 2'd2,
        ST_CHK_LO = 2'd3
    } deb_state_e;

    logic [1:0] raw_c;
    logic [1:0] level_c;
    logic [1:0] rise_c;

    assign raw_c = {sb_raw, sa_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        deb_state_e             state_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   level_q;
        logic                   rise_q;
        logic                   s_c;

        // Only the last synchroniser stage is ever looked at by the FSM
        assign s_c = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (!reset) begin
                sync_q  <= '0;
                state_q <= ST_LO;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_c[ch]};
                rise_q <= 1'b0;
                case (state_q)
                    ST_LO: begin
                        if (s_c) begin
                            state_q <= ST_CHK_HI;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    ST_CHK_HI: begin
                        if (!s_c) begin
                            state_q <= ST_LO;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                            state_q <= ST_HI;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_HI: begin
                        if (!s_c) begin
                            state_q <= ST_CHK_LO;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    ST_CHK_LO: begin
                        if (s_c) begin
                            state_q <= ST_HI;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                            state_q <= ST_LO;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_LO;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign level_c[ch] = level_q;
        assign rise_c[ch]  = rise_q;
    end

    // Timebase: counter wraps every TICK_DIV clocks, tick registered on the wrap edge
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            tick_q     <= 1'b0;
        end
    end

    assign sa      = level_c[0];
    assign sb      = level_c[1];
    assign sa_rise = rise_c[0];
    assign sb_rise = rise_c[1];
    assign tick    = tick_q;

endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce: a short-window instance for debounce
// behaviour and a default-parameter instance for reset latency and the timebase.
module tb_sensor_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Short-window instance (DEB_CYCLES=4)
    logic f_rst, f_sa_raw, f_sb_raw;
    logic f_sa, f_sb, f_sa_rise, f_sb_rise, f_tick;
    // Default-parameter instance
    logic d_rst, d_sa_raw, d_sb_raw;
    logic d_sa, d_sb, d_sa_rise, d_sb_rise, d_tick;

    int n_cmp = 0;
    int n_bad = 0;

    sensor_debounce #(.SYNC_STAGES(2), .DEB_CYCLES(4), .TICK_DIV(1000)) u_fast (
        .clk(clk), .reset(f_rst), .sa_raw(f_sa_raw), .sb_raw(f_sb_raw),
        .sa(f_sa), .sb(f_sb), .sa_rise(f_sa_rise), .sb_rise(f_sb_rise), .tick(f_tick)
    );

    sensor_debounce u_dflt (
        .clk(clk), .reset(d_rst), .sa_raw(d_sa_raw), .sb_raw(d_sb_raw),
        .sa(d_sa), .sb(d_sb), .sa_rise(d_sa_rise), .sb_rise(d_sb_rise), .tick(d_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rises;
        int ticks;

        f_rst = 1'b0; f_sa_raw = 1'b0; f_sb_raw = 1'b0;
        d_rst = 1'b0; d_sa_raw = 1'b1; d_sb_raw = 1'b1;

        // Reset values on both instances, raw lines high on the default one
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sa",   32'(d_sa),      32'd0);
            chk("rst_sb",   32'(d_sb),      32'd0);
            chk("rst_sar",  32'(d_sa_rise), 32'd0);
            chk("rst_sbr",  32'(d_sb_rise), 32'd0);
            chk("rst_tick", 32'(d_tick),    32'd0);
            chk("rst_fsa",  32'(f_sa),      32'd0);
        end

        // Clean press: output and pulse after edge 6
        f_rst = 1'b1; f_sa_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("press_sa",   32'(f_sa),      32'(e >= 6));
            chk("press_rise", 32'(f_sa_rise), 32'(e == 6));
        end

        // Clean release: output falls after edge 6, no pulse
        f_sa_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("rel_sa",   32'(f_sa),      32'(e < 6));
            chk("rel_rise", 32'(f_sa_rise), 32'd0);
        end

        // Bounce on B: 1,0,1,0,1 then hold 1; accept 6 edges after last change
        rises = 0;
        for (int e = 1; e <= 14; e++) begin
            if (e <= 5) f_sb_raw = (e % 2 == 1);
            step();
            chk("bnc_sb", 32'(f_sb), 32'(e >= 10));
            chk("bnc_sa", 32'(f_sa), 32'd0);
            if (f_sb_rise) rises++;
        end
        chk("bnc_rises", 32'(rises), 32'd1);

        // Three-clock glitch on A never reaches the output
        for (int e = 1; e <= 10; e++) begin
            f_sa_raw = (e <= 3);
            step();
            chk("glt_sa",   32'(f_sa),      32'd0);
            chk("glt_rise", 32'(f_sa_rise), 32'd0);
        end

        // Reach HI on A, then a one-clock reset clears it immediately
        f_sa_raw = 1'b1;
        for (int e = 1; e <= 8; e++) step();
        chk("mid_pre_sa", 32'(f_sa), 32'd1);
        f_rst = 1'b0;
        step();
        chk("mid_rst_sa",   32'(f_sa),      32'd0);
        chk("mid_rst_rise", 32'(f_sa_rise), 32'd0);
        chk("mid_rst_sb",   32'(f_sb),      32'd0);
        f_rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("mid_sa",   32'(f_sa),      32'(e >= 6));
            chk("mid_rise", 32'(f_sa_rise), 32'(e == 6));
        end

        // Default instance: release reset, raw lines already high; tick timebase
        // with concurrent bouncing on both channels
        d_rst = 1'b1;
        ticks = 0;
        for (int e = 1; e <= 5000; e++) begin
            step();
            chk("tick", 32'(d_tick), 32'(e % 1000 == 0));
            if (d_tick) ticks++;
            if (e >= 1001 && e <= 1003) begin
                chk("dflt_sa",  32'(d_sa),      32'(e >= 1002));
                chk("dflt_sar", 32'(d_sa_rise), 32'(e == 1002));
                chk("dflt_sb",  32'(d_sb),      32'(e >= 1002));
                chk("dflt_sbr", 32'(d_sb_rise), 32'(e == 1002));
            end
            if (e >= 2500 && e < 2700) d_sb_raw = ((e / 7) % 2 == 0);
            if (e >= 3500 && e < 3600) d_sa_raw = ((e / 3) % 2 == 0);
            if (e == 3600) d_sa_raw = 1'b1;
        end
        chk("tick_count", 32'(ticks), 32'd5);
        chk("end_sa", 32'(d_sa), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
